// File: rtl/fifo_sync_flags_pkg.sv
// Shared constants and elaboration helpers for the flagged synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int af_level,
                                        input int ae_level, input int fwft);
    return (depth >= 2) && (depth <= 1024) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1) &&
           ((fwft == FIFO_MODE_REG) || (fwft == FIFO_MODE_FWFT));
  endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer-facing signal bundle of fifo_sync_flags.
interface fifo_sync_flags_if import fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = fifo_count_width(DEPTH);

  // wr/rd are requests sampled every rising edge with no ready return path:
  // a write to a full FIFO (without a concurrent accepted read) or a read of an
  // empty FIFO is dropped and reported by a one-cycle overflow/underflow pulse.
  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             rd;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, data_in, rd,
    input  data_out, data_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd,
    output data_out, data_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_sync_flags_ptr.sv
// Pointer that counts 0..DEPTH-1 and wraps by explicit compare (any DEPTH).
module fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);
  localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + PW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy count, threshold flags, error pulses and
// a choice of registered or first-word-fall-through read.
module fifo_sync_flags import fifo_pkg::*; #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_MODE_REG
) (
  input logic               clk,
  input logic               rst,
  fifo_sync_flags_if.slave  bus
);
  localparam int CW = fifo_count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  if (!fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_params
    $error("fifo_sync_flags: illegal DEPTH/AF_LEVEL/AE_LEVEL/FWFT combination");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign w_rd_ok = bus.rd && !r_empty;
  assign w_wr_ok = bus.wr && (!r_full || w_rd_ok);

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_ok),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_ok),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[w_wr_ptr] <= bus.data_in;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Flags are derived from the next count so they line up with r_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == C_DEPTH);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= C_AF);
      r_almost_empty <= (w_count_nxt <= C_AE);
      r_overflow     <= bus.wr && !w_wr_ok;
      r_underflow    <= bus.rd && !w_rd_ok;
    end
  end

  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head entry shown directly; forced to zero while empty so reset reads 0.
    assign bus.data_out   = r_empty ? '0 : r_mem[w_rd_ptr];
    assign bus.data_valid = !r_empty;
  end else begin : g_reg
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_out   <= '0;
        r_data_valid <= 1'b0;
      end else begin
        r_data_valid <= w_rd_ok;
        if (w_rd_ok) begin
          r_data_out <= r_mem[w_rd_ptr];
        end
      end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: three configurations driven in lockstep, checked
// by directed expectations and a queue-based reference model.
module tb_fifo_sync_flags;

  localparam int N_DUT = 3;
  localparam int P_DEPTH [N_DUT] = '{8, 8, 5};
  localparam int P_AF    [N_DUT] = '{6, 6, 3};
  localparam int P_AE    [N_DUT] = '{2, 2, 2};
  localparam int P_FWFT  [N_DUT] = '{0, 1, 0};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] din;

  int checks   = 0;
  int failures = 0;

  // reference model: one queue per DUT, head at index 0
  logic [7:0] exp_q [N_DUT][$];
  logic       m_ovf  [N_DUT];
  logic       m_unf  [N_DUT];
  logic       m_dv   [N_DUT];
  logic [7:0] m_dout [N_DUT];

  fifo_sync_flags_if #(.WIDTH(8), .DEPTH(8)) if_a ();
  fifo_sync_flags_if #(.WIDTH(8), .DEPTH(8)) if_b ();
  fifo_sync_flags_if #(.WIDTH(8), .DEPTH(5)) if_c ();

  assign if_a.wr = wr;  assign if_a.rd = rd;  assign if_a.data_in = din;
  assign if_b.wr = wr;  assign if_b.rd = rd;  assign if_b.data_in = din;
  assign if_c.wr = wr;  assign if_c.rd = rd;  assign if_c.data_in = din;

  fifo_sync_flags #(.DEPTH(8), .WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );
  fifo_sync_flags #(.DEPTH(8), .WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );
  fifo_sync_flags #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(0)) u_dut_c (
    .clk (clk), .rst (rst), .bus (if_c.slave)
  );

  // status = {count[15:0], full, empty, almost_full, almost_empty, overflow, underflow, data_valid}
  function automatic logic [22:0] dut_status(input int k);
    logic [22:0] s;
    case (k)
      0:       s = {16'(if_a.count), if_a.full, if_a.empty, if_a.almost_full, if_a.almost_empty,
                    if_a.overflow, if_a.underflow, if_a.data_valid};
      1:       s = {16'(if_b.count), if_b.full, if_b.empty, if_b.almost_full, if_b.almost_empty,
                    if_b.overflow, if_b.underflow, if_b.data_valid};
      default: s = {16'(if_c.count), if_c.full, if_c.empty, if_c.almost_full, if_c.almost_empty,
                    if_c.overflow, if_c.underflow, if_c.data_valid};
    endcase
    return s;
  endfunction

  function automatic logic [7:0] dut_dout(input int k);
    logic [7:0] d;
    case (k)
      0:       d = if_a.data_out;
      1:       d = if_b.data_out;
      default: d = if_c.data_out;
    endcase
    return d;
  endfunction

  function automatic logic [22:0] exp_status(input int k);
    int   n;
    logic dv;
    n  = exp_q[k].size();
    dv = (P_FWFT[k] == 1) ? (n > 0) : m_dv[k];
    return {16'(n), (n == P_DEPTH[k]), (n == 0), (n >= P_AF[k]), (n <= P_AE[k]),
            m_ovf[k], m_unf[k], dv};
  endfunction

  function automatic bit exp_dout_known(input int k);
    return (P_FWFT[k] == 0) || (exp_q[k].size() > 0);
  endfunction

  function automatic logic [7:0] exp_dout(input int k);
    return (P_FWFT[k] == 1) ? exp_q[k][0] : m_dout[k];
  endfunction

  // driver: one clock; the model consumes the inputs sampled at this edge
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < N_DUT; k++) begin
      bit rd_ok;
      bit wr_ok;
      if (rst) begin
        exp_q[k].delete();
        m_ovf[k]  = 1'b0;
        m_unf[k]  = 1'b0;
        m_dv[k]   = 1'b0;
        m_dout[k] = 8'h00;
      end else begin
        rd_ok    = rd && (exp_q[k].size() > 0);
        wr_ok    = wr && ((exp_q[k].size() < P_DEPTH[k]) || rd_ok);
        m_ovf[k] = wr && !wr_ok;
        m_unf[k] = rd && !rd_ok;
        if (P_FWFT[k] == 0) begin
          m_dv[k] = rd_ok;
          if (rd_ok) m_dout[k] = exp_q[k][0];
        end
        if (rd_ok) void'(exp_q[k].pop_front());
        if (wr_ok) exp_q[k].push_back(din);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
    cycle();
    cycle();
    for (int k = 0; k < N_DUT; k++) begin
      checks++;
      if (dut_status(k) !== {16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_status dut%0d: got %h want %h", k, dut_status(k),
                 {16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      end
      checks++;
      if (dut_dout(k) !== 8'h00) begin
        failures++;
        $display("FAIL reset_dout dut%0d: got %h want 00", k, dut_dout(k));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals = '{8'd10, 8'd20, 8'd30};
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = vals[i];
      cycle();
      checks++;
      if (if_a.count !== 4'(i + 1)) begin
        failures++;
        $display("FAIL basic_wr_count %0d: got %0d want %0d", i, if_a.count, i + 1);
      end
    end
    wr = 1'b0;
    checks++;
    if ({if_b.data_valid, if_b.data_out} !== {1'b1, 8'd10}) begin
      failures++;
      $display("FAIL basic_fwft_head: got dv=%b d=%0d want dv=1 d=10", if_b.data_valid, if_b.data_out);
    end
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({if_a.data_valid, if_a.data_out, if_a.count} !== {1'b1, vals[i], 4'(2 - i)}) begin
        failures++;
        $display("FAIL basic_rd %0d: got dv=%b d=%0d cnt=%0d want dv=1 d=%0d cnt=%0d",
                 i, if_a.data_valid, if_a.data_out, if_a.count, vals[i], 2 - i);
      end
    end
    rd = 1'b0;
    cycle();
    checks++;
    if ({if_a.data_valid, if_a.empty} !== 2'b01) begin
      failures++;
      $display("FAIL basic_end: got dv=%b empty=%b want dv=0 empty=1", if_a.data_valid, if_a.empty);
    end
  endtask

  task automatic test_fill_overflow();
    wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(40 + i);
      cycle();
      checks++;
      if ({if_a.count, if_a.almost_full, if_a.full} !== {4'(i + 1), (i + 1 >= 6), (i == 7)}) begin
        failures++;
        $display("FAIL fill %0d: got cnt=%0d af=%b full=%b want cnt=%0d af=%b full=%b", i,
                 if_a.count, if_a.almost_full, if_a.full, i + 1, (i + 1 >= 6), (i == 7));
      end
    end
    din = 8'd48;
    cycle();
    wr = 1'b0;
    checks++;
    if ({if_a.overflow, if_a.count} !== {1'b1, 4'd8}) begin
      failures++;
      $display("FAIL overflow_pulse: got ovf=%b cnt=%0d want ovf=1 cnt=8", if_a.overflow, if_a.count);
    end
    cycle();
    checks++;
    if ({if_a.overflow, if_a.count} !== {1'b0, 4'd8}) begin
      failures++;
      $display("FAIL overflow_clear: got ovf=%b cnt=%0d want ovf=0 cnt=8", if_a.overflow, if_a.count);
    end
    rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if ({if_a.data_valid, if_a.data_out} !== {1'b1, 8'(40 + i)}) begin
        failures++;
        $display("FAIL drain %0d: got dv=%b d=%0d want dv=1 d=%0d", i, if_a.data_valid, if_a.data_out, 40 + i);
      end
    end
    rd = 1'b0;
    cycle();
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    checks++;
    if ({if_a.underflow, if_a.count, if_a.data_valid} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL underflow_pulse: got unf=%b cnt=%0d dv=%b want unf=1 cnt=0 dv=0",
               if_a.underflow, if_a.count, if_a.data_valid);
    end
    cycle();
    checks++;
    if ({if_a.underflow, if_a.data_valid} !== 2'b00) begin
      failures++;
      $display("FAIL underflow_clear: got unf=%b dv=%b want 0 0", if_a.underflow, if_a.data_valid);
    end
  endtask

  task automatic test_full_wr_rd();
    wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(60 + i);
      cycle();
    end
    rd = 1'b1;
    din = 8'd99;
    cycle();
    wr = 1'b0;
    checks++;
    if ({if_a.overflow, if_a.count, if_a.data_valid, if_a.data_out} !== {1'b0, 4'd8, 1'b1, 8'd60}) begin
      failures++;
      $display("FAIL full_wr_rd: got ovf=%b cnt=%0d dv=%b d=%0d want ovf=0 cnt=8 dv=1 d=60",
               if_a.overflow, if_a.count, if_a.data_valid, if_a.data_out);
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (if_a.data_out !== ((i == 7) ? 8'd99 : 8'(61 + i))) begin
        failures++;
        $display("FAIL full_drain %0d: got %0d want %0d", i, if_a.data_out, (i == 7) ? 99 : 61 + i);
      end
    end
    rd = 1'b0;
    cycle();
  endtask

  task automatic test_fwft();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (if_b.data_valid !== 1'b0) begin
      failures++;
      $display("FAIL fwft_idle_valid: got %b want 0", if_b.data_valid);
    end
    wr  = 1'b1;
    din = 8'h55;
    cycle();
    wr = 1'b0;
    checks++;
    if ({if_b.data_valid, if_b.data_out} !== {1'b1, 8'h55}) begin
      failures++;
      $display("FAIL fwft_show: got dv=%b d=%h want dv=1 d=55", if_b.data_valid, if_b.data_out);
    end
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    checks++;
    if ({if_b.empty, if_b.data_valid} !== 2'b10) begin
      failures++;
      $display("FAIL fwft_pop: got empty=%b dv=%b want empty=1 dv=0", if_b.empty, if_b.data_valid);
    end
    checks++;
    if ({if_a.data_valid, if_a.data_out} !== {1'b1, 8'h55}) begin
      failures++;
      $display("FAIL fwft_reg_peer: got dv=%b d=%h want dv=1 d=55", if_a.data_valid, if_a.data_out);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int j = 0; j < 14; j++) begin
      wr  = (j < 12);
      rd  = (j >= 2);
      din = 8'(100 + j);
      cycle();
      for (int k = 0; k < N_DUT; k++) begin
        checks++;
        if (dut_status(k) !== exp_status(k)) begin
          failures++;
          $display("FAIL wrap_status c%0d dut%0d: got %h want %h", j, k, dut_status(k), exp_status(k));
        end
        if (exp_dout_known(k)) begin
          checks++;
          if (dut_dout(k) !== exp_dout(k)) begin
            failures++;
            $display("FAIL wrap_data c%0d dut%0d: got %h want %h", j, k, dut_dout(k), exp_dout(k));
          end
        end
      end
    end
    rd = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(200 + i);
      cycle();
    end
    wr = 1'b0;
    checks++;
    if (if_c.count !== 3'd3) begin
      failures++;
      $display("FAIL wrap_pre_rst_count: got %0d want 3", if_c.count);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({if_c.count, if_c.empty, if_c.almost_empty} !== {3'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL wrap_mid_rst: got cnt=%0d empty=%b ae=%b want cnt=0 empty=1 ae=1",
               if_c.count, if_c.empty, if_c.almost_empty);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 600; j++) begin
      // alternate fill-biased and drain-biased phases to reach both ends
      int wr_pct;
      wr_pct = ((j / 50) % 2 == 0) ? 70 : 30;
      wr  = ($urandom_range(0, 99) < wr_pct);
      rd  = ($urandom_range(0, 99) < (100 - wr_pct));
      rst = ($urandom_range(0, 79) == 0);
      din = 8'($urandom);
      cycle();
      for (int k = 0; k < N_DUT; k++) begin
        checks++;
        if (dut_status(k) !== exp_status(k)) begin
          failures++;
          $display("FAIL rand_status c%0d dut%0d: got %h want %h", j, k, dut_status(k), exp_status(k));
        end
        if (exp_dout_known(k)) begin
          checks++;
          if (dut_dout(k) !== exp_dout(k)) begin
            failures++;
            $display("FAIL rand_data c%0d dut%0d: got %h want %h", j, k, dut_dout(k), exp_dout(k));
          end
        end
      end
    end
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr  = 1'b0;
    rd  = 1'b0;
    din = 8'h00;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_underflow();
    test_full_wr_rd();
    test_fwft();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
